// File: rtl/issue_decoder.sv
// RV32I issue decoder: decodes one instruction per handshake into a single holding entry,
// then strobes it to the reservation station (ALU/branch/jump) or the load-store buffer (memory).
module issue_decoder #(
    parameter int unsigned REG_ID_BIT = 5,
    parameter int unsigned OP_BIT     = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [31:0]           inst,
    input  logic [31:0]           inst_pc_in,
    input  logic                  rs_full,
    input  logic                  lsb_full,
    input  logic                  rob_full,
    input  logic                  flush,
    output logic                  to_rs,
    output logic                  to_lsb,
    output logic [OP_BIT-1:0]     op_type,
    output logic [REG_ID_BIT-1:0] rd,
    output logic [REG_ID_BIT-1:0] rs1,
    output logic [REG_ID_BIT-1:0] rs2,
    output logic [31:0]           imm,
    output logic [31:0]           inst_pc
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [OP_BIT-1:0]     op;
        logic [REG_ID_BIT-1:0] rd;
        logic [REG_ID_BIT-1:0] rs1;
        logic [REG_ID_BIT-1:0] rs2;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic                  is_mem;
    } dec_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    dec_t dec;
    dec_t hold_q;
    logic held_valid;
    logic dec_legal;
    logic can_issue;
    logic accept;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    // Immediate formats, all sign-extended except U (already full width) and shamt
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'h000};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = XLEN'(inst[24:20]);

    // Combinational decode of the presented instruction; op stays 0 for anything not RV32I
    always_comb begin
        dec        = '0;
        dec.pc     = inst_pc_in;
        dec.rd     = REG_ID_BIT'(inst[11:7]);
        dec.rs1    = REG_ID_BIT'(inst[19:15]);
        dec.rs2    = '0;
        dec.is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
        case (opc)
            OPC_LUI: begin
                dec.op  = OP_BIT'(1);
                dec.rs1 = '0;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.op  = OP_BIT'(2);
                dec.rs1 = '0;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.op  = OP_BIT'(3);
                dec.rs1 = '0;
                dec.imm = imm_j;
            end
            OPC_JALR: begin
                dec.op  = (f3 == 3'd0) ? OP_BIT'(4) : '0;
                dec.imm = imm_i;
            end
            OPC_BRANCH: begin
                dec.rd  = '0;
                dec.rs2 = REG_ID_BIT'(inst[24:20]);
                dec.imm = imm_b;
                case (f3)
                    3'd0:    dec.op = OP_BIT'(5);
                    3'd1:    dec.op = OP_BIT'(6);
                    3'd4:    dec.op = OP_BIT'(7);
                    3'd5:    dec.op = OP_BIT'(8);
                    3'd6:    dec.op = OP_BIT'(9);
                    3'd7:    dec.op = OP_BIT'(10);
                    default: dec.op = '0;
                endcase
            end
            OPC_LOAD: begin
                dec.imm = imm_i;
                case (f3)
                    3'd0:    dec.op = OP_BIT'(11);
                    3'd1:    dec.op = OP_BIT'(12);
                    3'd2:    dec.op = OP_BIT'(13);
                    3'd4:    dec.op = OP_BIT'(14);
                    3'd5:    dec.op = OP_BIT'(15);
                    default: dec.op = '0;
                endcase
            end
            OPC_STORE: begin
                dec.rd  = '0;
                dec.rs2 = REG_ID_BIT'(inst[24:20]);
                dec.imm = imm_s;
                case (f3)
                    3'd0:    dec.op = OP_BIT'(16);
                    3'd1:    dec.op = OP_BIT'(17);
                    3'd2:    dec.op = OP_BIT'(18);
                    default: dec.op = '0;
                endcase
            end
            OPC_OPIMM: begin
                dec.imm = imm_i;
                case (f3)
                    3'd0: dec.op = OP_BIT'(19);
                    3'd2: dec.op = OP_BIT'(20);
                    3'd3: dec.op = OP_BIT'(21);
                    3'd4: dec.op = OP_BIT'(22);
                    3'd6: dec.op = OP_BIT'(23);
                    3'd7: dec.op = OP_BIT'(24);
                    3'd1: begin
                        dec.imm = imm_sh;
                        dec.op  = (f7 == F7_ZERO) ? OP_BIT'(25) : '0;
                    end
                    default: begin
                        dec.imm = imm_sh;
                        if (f7 == F7_ZERO)
                            dec.op = OP_BIT'(26);
                        else if (f7 == F7_ALT)
                            dec.op = OP_BIT'(27);
                        else
                            dec.op = '0;
                    end
                endcase
            end
            OPC_OP: begin
                dec.rs2 = REG_ID_BIT'(inst[24:20]);
                case ({f7, f3})
                    {F7_ZERO, 3'd0}: dec.op = OP_BIT'(28);
                    {F7_ALT,  3'd0}: dec.op = OP_BIT'(29);
                    {F7_ZERO, 3'd1}: dec.op = OP_BIT'(30);
                    {F7_ZERO, 3'd2}: dec.op = OP_BIT'(31);
                    {F7_ZERO, 3'd3}: dec.op = OP_BIT'(32);
                    {F7_ZERO, 3'd4}: dec.op = OP_BIT'(33);
                    {F7_ZERO, 3'd5}: dec.op = OP_BIT'(34);
                    {F7_ALT,  3'd5}: dec.op = OP_BIT'(35);
                    {F7_ZERO, 3'd6}: dec.op = OP_BIT'(36);
                    {F7_ZERO, 3'd7}: dec.op = OP_BIT'(37);
                    default:         dec.op = '0;
                endcase
            end
            default: dec.op = '0;
        endcase
    end

    assign dec_legal  = (dec.op != '0);
    assign can_issue  = held_valid & ~rob_full & (hold_q.is_mem ? ~lsb_full : ~rs_full);
    assign inst_ready = rdy_in & ~flush & (~held_valid | can_issue);
    assign accept     = inst_valid & inst_ready;

    // Holding entry and issue registers; rdy_in low freezes everything including the strobes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            held_valid <= 1'b0;
            hold_q     <= '0;
            to_rs      <= 1'b0;
            to_lsb     <= 1'b0;
            op_type    <= '0;
            rd         <= '0;
            rs1        <= '0;
            rs2        <= '0;
            imm        <= '0;
            inst_pc    <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                held_valid <= 1'b0;
                to_rs      <= 1'b0;
                to_lsb     <= 1'b0;
            end else begin
                to_rs      <= can_issue & ~hold_q.is_mem;
                to_lsb     <= can_issue & hold_q.is_mem;
                held_valid <= (accept & dec_legal) | (held_valid & ~can_issue);
                if (accept && dec_legal)
                    hold_q <= dec;
                if (can_issue) begin
                    op_type <= hold_q.op;
                    rd      <= hold_q.rd;
                    rs1     <= hold_q.rs1;
                    rs2     <= hold_q.rs2;
                    imm     <= hold_q.imm;
                    inst_pc <= hold_q.pc;
                end
            end
        end
    end

endmodule

// File: doc/issue_decoder.md
Name: issue_decoder

Overview:
- Front-end stage that sits between the instruction queue and the out-of-order back end.
- Accepts one fetched RV32I instruction and its PC per handshake and decodes it into op_type, rd, rs1, rs2 and imm.
- Drives the reservation-station issue port (to_rs plus fields) for ALU/branch/jump ops, and the load-store-buffer port (to_lsb plus the same fields) for memory ops.
- Stalls on back-pressure; the ROB flushes it on mispredict.

Parameters:
REG_ID_BIT, 5, register index width
OP_BIT, 6, op_type width

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset; asynchronous, active-high
rdy_in  input  1  global pause when low
inst_valid  input  1  instruction queue has an instruction
inst_ready  output  1  decoder accepts this cycle
inst  input  32  raw instruction word
inst_pc_in  input  32  PC of inst
rs_full  input  1  reservation station cannot take an entry
lsb_full  input  1  load-store buffer cannot take an entry
rob_full  input  1  reorder buffer cannot take an entry
flush  input  1  mispredict clear from ROB
to_rs  output  1  one-cycle issue strobe to RS
to_lsb  output  1  one-cycle issue strobe to LSB
op_type  output  OP_BIT  decoded operation
rd  output  REG_ID_BIT  destination register
rs1  output  REG_ID_BIT  source 1
rs2  output  REG_ID_BIT  source 2
imm  output  32  sign-extended immediate
inst_pc  output  32  PC of issued instruction

Behaviour:
- Reset (async, rst_in high): held_valid=0, to_rs=0, to_lsb=0, op_type=0, rd=0, rs1=0, rs2=0, imm=0, inst_pc=0. inst_ready is 1 once reset deasserts.
- op_type encoding (0 = illegal):
  - LUI 1, AUIPC 2, JAL 3, JALR 4
  - BEQ..BGEU 5..10 (BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - LB, LH, LW, LBU, LHU 11..15; SB, SH, SW 16..18
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI 19..27
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND 28..37
- Field rules:
  - Unused register fields are forced to 0: rd for branches and stores; rs1 for LUI, AUIPC and JAL; rs2 for every non-R, non-B, non-S op.
  - imm per RISC-V format, sign-extended to 32 bits.
  - U-type imm = inst[31:12]<<12.
  - Shift-immediate imm = zero-extended shamt inst[24:20].
  - R-type imm = 0.
- Holding register: one entry (held_valid plus decoded fields plus PC). Decode is combinational on inst; the result is captured on accept.
- can_issue = held_valid & !rob_full & (is_mem ? !lsb_full : !rs_full).
- inst_ready = !held_valid | can_issue (combinational). Accept when inst_valid & inst_ready.
- Each active edge (rdy_in=1, flush=0):
  - to_rs <= can_issue & !is_mem; to_lsb <= can_issue & is_mem.
  - When can_issue, the field outputs load from the holding register.
  - held_valid <= accept | (held_valid & !can_issue).
  - Sustained throughput is 1 instruction/cycle; latency is 2 edges from accept to strobe.
- Illegal op (op_type 0): accepted and dropped. held_valid is not set and no strobe is issued.
- flush=1 at an edge overrides everything: held_valid=0, to_rs=0, to_lsb=0, no accept. inst_ready=0 while flush is high. Field outputs keep stale values.
- rdy_in=0: every register holds, including to_rs/to_lsb (the consumer is paused on the same edges). No accept: inst_ready=0.
- to_rs and to_lsb are never both 1. Field outputs are don't-care when both strobes are 0.

Test Plan:
- ADDI x1,x0,5 (0x00500093, pc 0x100), no stalls -> 2 edges after accept: to_rs=1 for 1 cycle, op_type=19, rd=1, rs1=0, rs2=0, imm=5, inst_pc=0x100.
- SW x2,8(x1) (0x0020A423) -> to_lsb=1, to_rs=0, op_type=18, rd=0, rs1=1, rs2=2, imm=8.
- BEQ x1,x2,-4 (0xFE208EE3) -> to_rs=1, op_type=5, rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC.
- ADD held while rs_full=1 for 3 cycles -> to_rs=0 and inst_ready=0 throughout. rs_full drops -> to_rs pulses once next edge and inst_ready returns to 1. Then back-to-back ADDIs -> one strobe per cycle.
- Instruction held, flush=1 for one cycle -> no strobe ever for it; inst_ready=0 during flush, 1 after. Separately, 0xFFFFFFFF -> accepted, no strobe.
- Assert rst_in mid-stream with a strobe high -> to_rs/to_lsb drop immediately (async), before the next clock edge. rdy_in=0 with to_rs=1 -> to_rs stays 1 until the first edge with rdy_in=1.
